cpu_pipeline_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage MIPS core. It merges the hazard unit's per-stage stall/flush requests with three other sources: multi-cycle data-memory wait, a syscall halt request, and debug resume/single-step. It drives the final stalls/flushs buses to the IF/ID/EX/MEM/WB stage registers and keeps run/wait cycle counters for the board display.

---
 rtl/cpu_pipeline_ctrl_pkg.sv | 14 +
 rtl/cpu_wait_timer.sv | 37 +++
 rtl/cpu_pipeline_ctrl.sv | 141 ++++++++++++++
 tb/tb_cpu_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and its wait timer.
package cpu_pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    STEP  = 2'd2,
    FAULT = 2'd3
  } ctrl_state_t;

  localparam logic [4:0] STALL_ALL = 5'b11111;
  localparam logic [4:0] NONE      = 5'b00000;

endpackage

// File: rtl/cpu_wait_timer.sv
// Counts consecutive busy cycles while enabled; expired flags the cycle that
// would make the run reach LIMIT. LIMIT=0 never expires.
module cpu_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic busy,
  output logic expired
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!en || !busy) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (LIMIT != 0) && en && busy && (count_q == LAST);

endmodule

// File: rtl/cpu_pipeline_ctrl.sv
// Pipeline sequencer: merges hazard, memory-wait, syscall-halt and debug
// control into final stall/flush buses. Optional macro: CPU_PIPE_CTRL_TIMEOUT_EN.
module cpu_pipeline_ctrl
  import cpu_pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  hz_stalls,
  input  logic [4:0]  hz_flushs,
  input  logic        mem_busy,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        step,
  output logic [4:0]  stalls,
  output logic [4:0]  flushs,
  output logic [1:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [31:0] run_cycle_count,
  output logic [31:0] wait_cycle_count
);

  localparam ctrl_state_t RESET_STATE = START_HALTED ? HALT : RUN;

  ctrl_state_t state_q, state_d;
  logic        halt_pend_q, halt_pend_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        active;
  logic        timeout_hit;

  assign active = (state_q == RUN) || (state_q == STEP);

`ifdef CPU_PIPE_CTRL_TIMEOUT_EN
  cpu_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .clr    (clr),
    .en     (active),
    .busy   (mem_busy),
    .expired(timeout_hit)
  );
`else
  logic unused_mem_timeout;
  assign unused_mem_timeout = (MEM_TIMEOUT == 0);
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    run_cnt_d   = run_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    stalls      = STALL_ALL;
    flushs      = NONE;

    if (active) begin
      run_cnt_d = run_cnt_q + 32'd1;
      if (mem_busy) begin
        wait_cnt_d = wait_cnt_q + 32'd1;
      end else begin
        stalls = hz_stalls;
        flushs = hz_flushs;
      end
    end

    unique case (state_q)
      RUN: begin
        // A halt seen while memory is busy is parked in halt_pend until the access completes.
        if (mem_busy) begin
          if (timeout_hit) begin
            state_d = FAULT;
          end else if (halt_req) begin
            halt_pend_d = 1'b1;
          end
        end else if (halt_pend_q || halt_req) begin
          state_d     = HALT;
          halt_pend_d = 1'b0;
        end
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
        end else if (step) begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (!mem_busy) begin
          state_d = HALT;
        end else if (timeout_hit) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase

    if (clr) begin
      state_d     = RESET_STATE;
      halt_pend_d = 1'b0;
      run_cnt_d   = '0;
      wait_cnt_d  = '0;
      stalls      = NONE;
      flushs      = STALL_ALL;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= RESET_STATE;
      halt_pend_q <= 1'b0;
      run_cnt_q   <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      run_cnt_q   <= run_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign state            = state_q;
  assign halted           = (state_q == HALT);
`ifdef CPU_PIPE_CTRL_TIMEOUT_EN
  assign fault            = (state_q == FAULT);
`else
  assign fault            = 1'b0;
`endif
  assign run_cycle_count  = run_cnt_q;
  assign wait_cycle_count = wait_cnt_q;

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// Bench for cpu_pipeline_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencer rules.
module tb_cpu_pipeline_ctrl;

  localparam int unsigned TB_MEM_TIMEOUT  = 4;
  localparam bit          TB_START_HALTED = 1'b0;
`ifdef CPU_PIPE_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int S_RUN = 0, S_HALT = 1, S_STEP = 2, S_FAULT = 3;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  hz_stalls, hz_flushs;
  logic        mem_busy, halt_req, resume, step;
  logic [4:0]  stalls, flushs;
  logic [1:0]  state;
  logic        halted, fault;
  logic [31:0] run_cycle_count, wait_cycle_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int          m_state;
  bit          m_pend;
  logic [31:0] m_run, m_wait;
  int          m_streak;

  cpu_pipeline_ctrl #(
    .MEM_TIMEOUT (TB_MEM_TIMEOUT),
    .START_HALTED(TB_START_HALTED)
  ) dut (
    .clk             (clk),
    .clr             (clr),
    .hz_stalls       (hz_stalls),
    .hz_flushs       (hz_flushs),
    .mem_busy        (mem_busy),
    .halt_req        (halt_req),
    .resume          (resume),
    .step            (step),
    .stalls          (stalls),
    .flushs          (flushs),
    .state           (state),
    .halted          (halted),
    .fault           (fault),
    .run_cycle_count (run_cycle_count),
    .wait_cycle_count(wait_cycle_count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = TB_START_HALTED ? S_HALT : S_RUN;
    m_pend   = 1'b0;
    m_run    = '0;
    m_wait   = '0;
    m_streak = 0;
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_step();
    bit in_run_or_step;
    bit timed_out;
    if (clr) begin
      model_reset();
      return;
    end
    in_run_or_step = (m_state == S_RUN) || (m_state == S_STEP);
    if (in_run_or_step) begin
      m_run = m_run + 32'd1;
      if (mem_busy) m_wait = m_wait + 32'd1;
    end
    m_streak  = (in_run_or_step && mem_busy) ? m_streak + 1 : 0;
    timed_out = TMO_EN && (TB_MEM_TIMEOUT != 0) && (m_streak >= TB_MEM_TIMEOUT);
    case (m_state)
      S_RUN: begin
        if (mem_busy) begin
          if (timed_out) m_state = S_FAULT;
          else if (halt_req) m_pend = 1'b1;
        end else if (m_pend || halt_req) begin
          m_state = S_HALT;
          m_pend  = 1'b0;
        end
      end
      S_HALT: begin
        if (resume) m_state = S_RUN;
        else if (step) m_state = S_STEP;
      end
      S_STEP: begin
        if (!mem_busy) m_state = S_HALT;
        else if (timed_out) m_state = S_FAULT;
      end
      default: ;
    endcase
  endtask

  // Driver: inputs change 1 time unit after the rising edge.
  task automatic drive(input logic c, input logic b, input logic h, input logic r,
                       input logic s, input logic [4:0] hs, input logic [4:0] hf);
    clr = c; mem_busy = b; halt_req = h; resume = r; step = s;
    hz_stalls = hs; hz_flushs = hf;
  endtask

  // Compare all outputs at the falling edge, then clock both DUT and model.
  task automatic cycle();
    logic [4:0] es, ef;
    @(negedge clk);
    if (clr) begin
      es = 5'b00000; ef = 5'b11111;
    end else if (m_state == S_HALT || m_state == S_FAULT || mem_busy) begin
      es = 5'b11111; ef = 5'b00000;
    end else begin
      es = hz_stalls; ef = hz_flushs;
    end
    check("stalls", {27'b0, stalls}, {27'b0, es});
    check("flushs", {27'b0, flushs}, {27'b0, ef});
    check("state", {30'b0, state}, 32'(m_state));
    check("halted", {31'b0, halted}, {31'b0, m_state == S_HALT});
    check("fault", {31'b0, fault}, {31'b0, m_state == S_FAULT});
    check("run_cycle_count", run_cycle_count, m_run);
    check("wait_cycle_count", wait_cycle_count, m_wait);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    // Reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 5'b00000);
    @(posedge clk);
    #1;
    model_reset();
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 5'b00000);
    cycle();

    // Memory wait overrides hazards
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00110, 5'b01000);
    repeat (3) cycle();

    // Halt request parked behind a busy memory
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00001, 5'b00010);
    repeat (2) cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00100, 5'b00011);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00100, 5'b00011);
    repeat (3) cycle();

    // Single step, then step+resume together
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10100, 5'b00001);
    cycle();
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01010, 5'b10001);
    cycle();

    // Run counter wrap
    force dut.run_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.run_cnt_q;
    m_run = 32'hFFFF_FFFF;
    cycle();
    cycle();

    // Long memory wait (faults only when the timeout is built)
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00011, 5'b11100);
    repeat (10) cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00011, 5'b11100);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011, 5'b11100);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011, 5'b11100);
    cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 14) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0,
            5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
